// File: rtl/logic_eqn_bist_pkg.sv
// Shared types and helpers for the exhaustive logic-equation BIST family.
// Holds the sweep FSM encoding and the truth-table width helper.
package logic_eqn_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Table layout: bit [o*2**n_in + v] is output o for input vector v.
  function automatic int tt_width(input int n_in, input int n_out);
    return n_out * (2 ** n_in);
  endfunction

endpackage

// File: rtl/logic_eqn_bist_cmp.sv
// Picks the expected outputs for one vector from the latched truth table and flags a mismatch.
// Purely combinational, no flow control.
module logic_eqn_bist_cmp
  import logic_eqn_bist_pkg::*;
#(
  parameter  int N_IN  = 3,
  parameter  int N_OUT = 2,
  localparam int TT_W  = tt_width(N_IN, N_OUT)
) (
  input  logic [TT_W-1:0]  tt_i,
  input  logic [N_IN-1:0]  vec_i,
  input  logic [N_OUT-1:0] dut_out_i,
  output logic             mismatch_o
);

  localparam int VECS = 2 ** N_IN;

  logic [N_OUT-1:0] w_exp;

  for (genvar g = 0; g < N_OUT; g++) begin : g_row
    logic [VECS-1:0] w_row;
    assign w_row    = tt_i[g*VECS +: VECS];
    assign w_exp[g] = w_row[vec_i];
  end

  assign mismatch_o = |(w_exp ^ dut_out_i);

endmodule

// File: rtl/logic_eqn_structural.sv
// Small combinational block under test: F1 = XZ + YZ', F2 = XY' + YZ'.
// Zero latency, no flow control.
module logic_eqn_structural (
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  output logic f1_o,
  output logic f2_o
);

  logic w_yzn;

  assign w_yzn = y_i & ~z_i;
  assign f1_o  = (x_i & z_i) | w_yzn;
  assign f2_o  = (x_i & ~y_i) | w_yzn;

endmodule

// File: rtl/logic_eqn_bist.sv
// Exhaustive stimulus/response BIST: sweeps all 2**N_IN vectors, SETTLE_CYC+2 cycles each.
// No backpressure; start is ignored while busy, abort returns to idle on the next edge.
module logic_eqn_bist
  import logic_eqn_bist_pkg::*;
#(
  parameter  int N_IN       = 3,
  parameter  int N_OUT      = 2,
  parameter  int SETTLE_CYC = 2,
  localparam int TT_W       = tt_width(N_IN, N_OUT)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [TT_W-1:0]  exp_tt_i,
  input  logic [N_OUT-1:0] dut_out_i,
  output logic [N_IN-1:0]  pat_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [N_IN:0]    fail_cnt_o,
  output logic [N_IN-1:0]  first_fail_o
);

  localparam int              SC_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LOAD  = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_t          r_state;
  state_t          w_next;
  logic [N_IN-1:0] r_vec;
  logic [SC_W-1:0] r_settle;
  logic [TT_W-1:0] r_tt;
  logic            w_busy;
  logic            w_start;
  logic            w_abort;
  logic            w_mismatch;

  assign w_busy  = (r_state == ST_APPLY) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
  assign w_start = start_i && !abort_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_abort = abort_i && w_busy;

  logic_eqn_bist_cmp #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_cmp (
    .tt_i       (r_tt),
    .vec_i      (r_vec),
    .dut_out_i  (dut_out_i),
    .mismatch_o (w_mismatch)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start) w_next = ST_APPLY;
      ST_APPLY:         w_next = (SETTLE_CYC == 0) ? ST_CHECK : ST_WAIT;
      ST_WAIT:          if (r_settle == '0) w_next = ST_CHECK;
      ST_CHECK:         w_next = (r_vec == VEC_LAST) ? ST_DONE : ST_APPLY;
      default:          w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_vec        <= '0;
      r_settle     <= '0;
      r_tt         <= '0;
      pat_o        <= '0;
      fail_cnt_o   <= '0;
      first_fail_o <= '0;
    end else if (w_abort) begin
      r_vec        <= '0;
      pat_o        <= '0;
      fail_cnt_o   <= '0;
      first_fail_o <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_tt         <= exp_tt_i;
            r_vec        <= '0;
            fail_cnt_o   <= '0;
            first_fail_o <= '0;
          end
        end
        ST_APPLY: begin
          pat_o    <= r_vec;
          r_settle <= SC_LOAD;
        end
        ST_WAIT: begin
          if (r_settle != '0) r_settle <= r_settle - 1'b1;
        end
        ST_CHECK: begin
          // Count saturates naturally: at most 2**N_IN failures fit in N_IN+1 bits.
          if (w_mismatch) begin
            fail_cnt_o <= fail_cnt_o + 1'b1;
            if (fail_cnt_o == '0) first_fail_o <= r_vec;
          end
          if (r_vec != VEC_LAST) r_vec <= r_vec + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = w_busy;
  assign done_o = (r_state == ST_DONE);
  assign pass_o = done_o && (fail_cnt_o == '0);

endmodule

// File: tb/tb_logic_eqn_bist.sv
// Bench for logic_eqn_bist: randomized truth tables and injected output faults
// checked against a vector-by-vector reference of the sweep result and timing.
module tb_logic_eqn_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort;
  logic [15:0] exp_tt;
  logic [1:0]  inj_v [8];
  logic [2:0]  pat;
  logic        busy, done, pass;
  logic [3:0]  fail_cnt;
  logic [2:0]  first_fail;
  logic        f1, f2;
  logic [1:0]  dut_out;

  logic        start_z, abort_z;
  logic [15:0] exp_tt_z;
  logic [2:0]  pat_z;
  logic        busy_z, done_z, pass_z;
  logic [3:0]  fail_cnt_z;
  logic [2:0]  first_fail_z;
  logic        f1_z, f2_z;

  int n_chk = 0;
  int n_fail = 0;

  logic_eqn_structural u_eqn (.x_i(pat[2]), .y_i(pat[1]), .z_i(pat[0]), .f1_o(f1), .f2_o(f2));
  assign dut_out = {f2, f1} ^ inj_v[pat];

  logic_eqn_bist #(.N_IN(3), .N_OUT(2), .SETTLE_CYC(2)) u_bist (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .exp_tt_i(exp_tt), .dut_out_i(dut_out), .pat_o(pat), .busy_o(busy),
    .done_o(done), .pass_o(pass), .fail_cnt_o(fail_cnt), .first_fail_o(first_fail)
  );

  logic_eqn_structural u_eqn_z (.x_i(pat_z[2]), .y_i(pat_z[1]), .z_i(pat_z[0]), .f1_o(f1_z), .f2_o(f2_z));

  logic_eqn_bist #(.N_IN(3), .N_OUT(2), .SETTLE_CYC(0)) u_bist_z (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_z), .abort_i(abort_z),
    .exp_tt_i(exp_tt_z), .dut_out_i({f2_z, f1_z}), .pat_o(pat_z), .busy_o(busy_z),
    .done_o(done_z), .pass_o(pass_z), .fail_cnt_o(fail_cnt_z), .first_fail_o(first_fail_z)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  // F1 = XZ + YZ', F2 = XY' + YZ' with {x,y,z} = v
  function automatic logic [1:0] golden(input int v);
    logic x, y, z;
    x = v[2]; y = v[1]; z = v[0];
    return {(x & ~y) | (y & ~z), (x & z) | (y & ~z)};
  endfunction

  task automatic model(input logic [15:0] tt, input bit use_inj, output int nf, output int ff);
    logic [15:0] sh;
    logic [1:0]  obs, ex;
    nf = 0;
    ff = 0;
    for (int v = 0; v < 8; v++) begin
      sh  = tt >> v;
      ex  = {sh[8], sh[0]};
      obs = golden(v) ^ (use_inj ? inj_v[v] : 2'b00);
      if (obs != ex) begin
        if (nf == 0) ff = v;
        nf++;
      end
    end
  endtask

  task automatic run_sweep(input string tag, input logic [15:0] tt);
    int k, ep, bad_pat, bad_busy, nf, ff;
    model(tt, 1'b1, nf, ff);
    exp_tt = tt;
    start  = 1'b1;
    wait_clk();
    start  = 1'b0;
    exp_tt = 16'($urandom);
    k = 0; bad_pat = 0; bad_busy = 0;
    while (!done && k < 200) begin
      wait_clk();
      k++;
      if (!done) begin
        ep = (k - 1) / 4;
        if (ep > 7) ep = 7;
        if (pat !== 3'(ep)) bad_pat++;
        if (!busy) bad_busy++;
      end
    end
    check_eq({tag, ".done_lat"}, 32'(k), 32'd32);
    check_eq({tag, ".pat_seq_errs"}, 32'(bad_pat), 32'd0);
    check_eq({tag, ".busy_drops"}, 32'(bad_busy), 32'd0);
    check_eq({tag, ".pass"}, 32'(pass), 32'(nf == 0));
    check_eq({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(nf));
    if (nf != 0) check_eq({tag, ".first_fail"}, 32'(first_fail), 32'(ff));
    wait_clk();
    wait_clk();
    check_eq({tag, ".held"}, {26'd0, busy, done, fail_cnt}, {26'd0, 1'b0, 1'b1, 4'(nf)});
    check_eq({tag, ".pat_last"}, 32'(pat), 32'd7);
  endtask

  task automatic run_sweep_z(input string tag, input logic [15:0] tt);
    int k, nf, ff;
    model(tt, 1'b0, nf, ff);
    exp_tt_z = tt;
    start_z  = 1'b1;
    wait_clk();
    start_z  = 1'b0;
    k = 0;
    while (!done_z && k < 200) begin
      wait_clk();
      k++;
    end
    check_eq({tag, ".done_lat"}, 32'(k), 32'd16);
    check_eq({tag, ".pass"}, 32'(pass_z), 32'(nf == 0));
    check_eq({tag, ".fail_cnt"}, 32'(fail_cnt_z), 32'(nf));
    if (nf != 0) check_eq({tag, ".first_fail"}, 32'(first_fail_z), 32'(ff));
  endtask

  initial begin
    logic [15:0] gold_tt, mask;
    int k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tt = '0;
    start_z = 1'b0; abort_z = 1'b0; exp_tt_z = '0;
    for (int v = 0; v < 8; v++) inj_v[v] = 2'b00;
    gold_tt = '0;
    for (int v = 0; v < 8; v++) begin
      gold_tt[v]     = golden(v)[0];
      gold_tt[8 + v] = golden(v)[1];
    end
    wait_clk();
    wait_clk();
    check_eq("reset.main", {20'd0, pat, busy, done, pass, fail_cnt, first_fail}, 32'd0);
    check_eq("reset.z", {20'd0, pat_z, busy_z, done_z, pass_z, fail_cnt_z, first_fail_z}, 32'd0);
    rst_n = 1'b1;
    wait_clk();

    run_sweep("t1_pass", 16'h74E4);
    run_sweep("t2_f1v3", 16'h74EC);
    run_sweep("t3_allinv", 16'h8B1B);

    for (int it = 0; it < 8; it++) begin
      mask = 16'($urandom & $urandom & $urandom);
      for (int v = 0; v < 8; v++)
        inj_v[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      run_sweep($sformatf("rnd%0d", it), (it == 7) ? 16'($urandom) : (gold_tt ^ mask));
    end
    for (int v = 0; v < 8; v++) inj_v[v] = 2'b00;

    // abort mid-sweep with failures already counted
    exp_tt = 16'h8B1B;
    start  = 1'b1;
    wait_clk();
    start  = 1'b0;
    k = 0;
    while (pat != 3'd4 && k < 100) begin
      wait_clk();
      k++;
    end
    check_eq("abort.reach_pat4", 32'(pat), 32'd4);
    abort = 1'b1;
    wait_clk();
    abort = 1'b0;
    check_eq("abort.outs", {24'd0, busy, done, pass, pat}, 32'd0);
    check_eq("abort.counts", {25'd0, fail_cnt, first_fail}, 32'd0);
    abort = 1'b1;
    start = 1'b1;
    wait_clk();
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort.idle_noop", {30'd0, busy, done}, 32'd0);
    run_sweep("abort.rerun", 16'h74E4);

    // asynchronous reset mid-sweep
    exp_tt = 16'h8B1B;
    start  = 1'b1;
    wait_clk();
    start  = 1'b0;
    for (int i = 0; i < 10; i++) wait_clk();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst.async", {20'd0, pat, busy, done, pass, fail_cnt, first_fail}, 32'd0);
    wait_clk();
    rst_n = 1'b1;
    wait_clk();
    check_eq("rst.stays_idle", {30'd0, busy, done}, 32'd0);

    // start held high through a sweep, then restart from DONE
    exp_tt = 16'h74EC;
    start  = 1'b1;
    wait_clk();
    k = 0;
    while (!done && k < 200) begin
      wait_clk();
      k++;
    end
    check_eq("hold.done_lat", 32'(k), 32'd32);
    check_eq("hold.fail_cnt", 32'(fail_cnt), 32'd1);
    exp_tt = 16'h74E4;
    wait_clk();
    start = 1'b0;
    check_eq("restart.cleared", {26'd0, busy, done, fail_cnt}, {26'd0, 1'b1, 1'b0, 4'd0});
    k = 0;
    while (!done && k < 200) begin
      wait_clk();
      k++;
    end
    check_eq("restart.pass", {30'd0, done, pass}, 32'd3);

    run_sweep_z("z_pass", 16'h74E4);
    run_sweep_z("z_f1v3", 16'h74EC);
    run_sweep_z("z_rnd", gold_tt ^ 16'($urandom & $urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
